// File: rtl/ibuf_param.sv
// Parametrised fetch-to-decode instruction buffer: circular storage of DEPTH
// entries, up to IN_W writes and OUT_W reads per cycle, sticky overflow flag.
module ibuf_param #(
    parameter int DEPTH = 8,
    parameter int IN_W  = 2,
    parameter int OUT_W = 2,
    parameter int SLACK = 2,
    parameter int EXC_W = 6
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        flush,
    input  logic [$clog2(IN_W+1)-1:0]   in_size,
    output logic                        in_ready,
    input  logic [IN_W*32-1:0]          in_pc,
    input  logic [IN_W*32-1:0]          in_inst,
    input  logic [IN_W-1:0]             in_pred_taken,
    input  logic [IN_W*32-1:0]          in_pred_target,
    input  logic [IN_W-1:0]             in_have_exc,
    input  logic [IN_W*EXC_W-1:0]       in_exc_type,
    output logic [OUT_W-1:0]            out_valid,
    output logic [OUT_W*32-1:0]         out_pc,
    output logic [OUT_W*32-1:0]         out_inst,
    output logic [OUT_W-1:0]            out_pred_taken,
    output logic [OUT_W*32-1:0]         out_pred_target,
    output logic [OUT_W-1:0]            out_have_exc,
    output logic [OUT_W*EXC_W-1:0]      out_exc_type,
    input  logic [$clog2(OUT_W+1)-1:0]  consume,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [31:0]       pc_mem_r     [DEPTH];
    logic [31:0]       inst_mem_r   [DEPTH];
    logic              taken_mem_r  [DEPTH];
    logic [31:0]       target_mem_r [DEPTH];
    logic              exc_mem_r    [DEPTH];
    logic [EXC_W-1:0]  etype_mem_r  [DEPTH];

    logic [PTR_W-1:0]  head_r;
    logic [PTR_W-1:0]  tail_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;

    logic [CNT_W-1:0]  free_s;
    logic [CNT_W-1:0]  in_req_s;
    logic [CNT_W-1:0]  in_cap_s;
    logic [CNT_W-1:0]  eff_in_s;
    logic [CNT_W-1:0]  cons_req_s;
    logic [CNT_W-1:0]  eff_cons_s;
    logic              drop_s;
    logic              wr_en_s      [IN_W];
    logic [PTR_W-1:0]  wr_idx_s     [IN_W];
    logic [PTR_W-1:0]  rd_idx_s     [OUT_W];

    // Free space is judged on the pre-consume occupancy, so slots freed this cycle wait a cycle.
    always_comb begin
        free_s     = CNT_W'(DEPTH) - count_r;
        in_req_s   = CNT_W'(in_size);
        in_cap_s   = (in_req_s > CNT_W'(IN_W)) ? CNT_W'(IN_W) : in_req_s;
        eff_in_s   = (in_cap_s > free_s) ? free_s : in_cap_s;
        drop_s     = (in_req_s > eff_in_s);
        cons_req_s = CNT_W'(consume);
        eff_cons_s = (cons_req_s > count_r) ? count_r : cons_req_s;
    end

    // Per-lane write enables and target slots; reset and flush suppress all writes.
    always_comb begin
        for (int i = 0; i < IN_W; i++) begin
            wr_idx_s[i] = tail_r + PTR_W'(i);
            wr_en_s[i]  = resetn && !flush && (CNT_W'(i) < eff_in_s);
        end
    end

    // Entry storage; deliberately not reset, validity comes from count_r.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_W; i++) begin
            if (wr_en_s[i]) begin
                pc_mem_r[wr_idx_s[i]]     <= in_pc[32*i +: 32];
                inst_mem_r[wr_idx_s[i]]   <= in_inst[32*i +: 32];
                taken_mem_r[wr_idx_s[i]]  <= in_pred_taken[i];
                target_mem_r[wr_idx_s[i]] <= in_pred_target[32*i +: 32];
                exc_mem_r[wr_idx_s[i]]    <= in_have_exc[i];
                etype_mem_r[wr_idx_s[i]]  <= in_exc_type[EXC_W*i +: EXC_W];
            end
        end
    end

    // Pointer, occupancy and sticky overflow state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (flush) begin
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= overflow_r;
        end else begin
            head_r     <= head_r + eff_cons_s[PTR_W-1:0];
            tail_r     <= tail_r + eff_in_s[PTR_W-1:0];
            count_r    <= count_r + eff_in_s - eff_cons_s;
            overflow_r <= overflow_r | drop_s;
        end
    end

    // Read slots for each decode lane, relative to the registered head.
    always_comb begin
        for (int j = 0; j < OUT_W; j++) begin
            rd_idx_s[j] = head_r + PTR_W'(j);
        end
    end

    // Output lanes driven purely from registered state.
    always_comb begin
        out_valid       = {OUT_W{1'b0}};
        out_pc          = {(OUT_W*32){1'b0}};
        out_inst        = {(OUT_W*32){1'b0}};
        out_pred_taken  = {OUT_W{1'b0}};
        out_pred_target = {(OUT_W*32){1'b0}};
        out_have_exc    = {OUT_W{1'b0}};
        out_exc_type    = {(OUT_W*EXC_W){1'b0}};
        for (int j = 0; j < OUT_W; j++) begin
            out_valid[j]                     = (count_r > CNT_W'(j));
            out_pc[32*j +: 32]               = pc_mem_r[rd_idx_s[j]];
            out_inst[32*j +: 32]             = inst_mem_r[rd_idx_s[j]];
            out_pred_taken[j]                = taken_mem_r[rd_idx_s[j]];
            out_pred_target[32*j +: 32]      = target_mem_r[rd_idx_s[j]];
            out_have_exc[j]                  = exc_mem_r[rd_idx_s[j]];
            out_exc_type[EXC_W*j +: EXC_W]   = etype_mem_r[rd_idx_s[j]];
        end
    end

    assign in_ready     = (free_s >= CNT_W'(IN_W + SLACK));
    assign count        = count_r;
    assign overflow_err = overflow_r;

endmodule

// File: tb/tb_ibuf_param.sv
// Directed bench for ibuf_param: a queue scoreboard holds the expected buffer
// contents in order and every cycle's outputs are compared against it.
module tb_ibuf_param;

    localparam int DEPTH = 8;
    localparam int IN_W  = 2;
    localparam int OUT_W = 2;
    localparam int SLACK = 2;
    localparam int EXC_W = 6;
    localparam int ISZ_W = $clog2(IN_W+1);
    localparam int CON_W = $clog2(OUT_W+1);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      inst;
        logic             taken;
        logic [31:0]      target;
        logic             exc;
        logic [EXC_W-1:0] et;
    } ent_t;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   flush;
    logic [ISZ_W-1:0]       in_size;
    logic                   in_ready;
    logic [IN_W*32-1:0]     in_pc;
    logic [IN_W*32-1:0]     in_inst;
    logic [IN_W-1:0]        in_pred_taken;
    logic [IN_W*32-1:0]     in_pred_target;
    logic [IN_W-1:0]        in_have_exc;
    logic [IN_W*EXC_W-1:0]  in_exc_type;
    logic [OUT_W-1:0]       out_valid;
    logic [OUT_W*32-1:0]    out_pc;
    logic [OUT_W*32-1:0]    out_inst;
    logic [OUT_W-1:0]       out_pred_taken;
    logic [OUT_W*32-1:0]    out_pred_target;
    logic [OUT_W-1:0]       out_have_exc;
    logic [OUT_W*EXC_W-1:0] out_exc_type;
    logic [CON_W-1:0]       consume;
    logic [CNT_W-1:0]       count;
    logic                   overflow_err;

    ibuf_param #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .SLACK(SLACK), .EXC_W(EXC_W)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .in_size(in_size), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_pred_taken(in_pred_taken),
        .in_pred_target(in_pred_target), .in_have_exc(in_have_exc), .in_exc_type(in_exc_type),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
        .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target),
        .out_have_exc(out_have_exc), .out_exc_type(out_exc_type),
        .consume(consume), .count(count), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int               checks = 0;
    int               errors = 0;
    ent_t             sb_q [$];
    logic             exp_ovf = 1'b0;
    logic [31:0]      lane_pc  [IN_W];
    logic             lane_exc [IN_W];
    logic [EXC_W-1:0] lane_et  [IN_W];
    logic [31:0]      next_pc;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t lane_ent(input int i);
        ent_t e;
        e.pc     = lane_pc[i];
        e.inst   = lane_pc[i] ^ 32'hA5A5_5A5A;
        e.taken  = lane_pc[i][2];
        e.target = lane_pc[i] + 32'h0000_0040;
        e.exc    = lane_exc[i];
        e.et     = lane_et[i];
        return e;
    endfunction

    task automatic load(input logic [31:0] base);
        for (int i = 0; i < IN_W; i++) begin
            lane_pc[i]  = base + 32'(4 * i);
            lane_exc[i] = 1'b0;
            lane_et[i]  = {EXC_W{1'b0}};
        end
    endtask

    task automatic check_outputs();
        logic [OUT_W-1:0] exp_valid;
        logic             exp_ready;
        ent_t             act;
        for (int j = 0; j < OUT_W; j++) exp_valid[j] = (sb_q.size() > j);
        exp_ready = ((DEPTH - sb_q.size()) >= (IN_W + SLACK));
        check("count", 128'(count), 128'(sb_q.size()));
        check("out_valid", 128'(out_valid), 128'(exp_valid));
        check("in_ready", 128'(in_ready), 128'(exp_ready));
        check("overflow_err", 128'(overflow_err), 128'(exp_ovf));
        for (int j = 0; j < OUT_W; j++) begin
            if (j < sb_q.size()) begin
                act.pc     = out_pc[32*j +: 32];
                act.inst   = out_inst[32*j +: 32];
                act.taken  = out_pred_taken[j];
                act.target = out_pred_target[32*j +: 32];
                act.exc    = out_have_exc[j];
                act.et     = out_exc_type[EXC_W*j +: EXC_W];
                check($sformatf("lane%0d_entry", j), 128'(act), 128'(sb_q[j]));
            end
        end
    endtask

    // rst=1 asserts resetn low for this cycle
    task automatic cycle(input logic rst, input logic fl, input int sz, input int cons);
        int   mc;
        int   ei;
        int   ec;
        ent_t e;
        mc = sb_q.size();
        if (rst) begin
            sb_q.delete();
            exp_ovf = 1'b0;
        end else if (fl) begin
            sb_q.delete();
        end else begin
            ei = (sz > IN_W) ? IN_W : sz;
            if (ei > DEPTH - mc) ei = DEPTH - mc;
            ec = (cons > mc) ? mc : cons;
            repeat (ec) void'(sb_q.pop_front());
            for (int i = 0; i < ei; i++) sb_q.push_back(lane_ent(i));
            if (sz > ei) exp_ovf = 1'b1;
        end
        resetn  = ~rst;
        flush   = fl;
        in_size = ISZ_W'(sz);
        consume = CON_W'(cons);
        for (int i = 0; i < IN_W; i++) begin
            e = lane_ent(i);
            in_pc[32*i +: 32]             = e.pc;
            in_inst[32*i +: 32]           = e.inst;
            in_pred_taken[i]              = e.taken;
            in_pred_target[32*i +: 32]    = e.target;
            in_have_exc[i]                = e.exc;
            in_exc_type[EXC_W*i +: EXC_W] = e.et;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        load(32'h0000_1000);
        resetn = 1'b0; flush = 1'b0; in_size = '0; consume = '0;
        in_pc = '0; in_inst = '0; in_pred_taken = '0; in_pred_target = '0;
        in_have_exc = '0; in_exc_type = '0;

        // reset held two cycles while fetch presents two lanes
        cycle(1'b1, 1'b0, 2, 0);
        cycle(1'b1, 1'b0, 2, 0);

        // fill to full, then one write that must be dropped
        next_pc = 32'h0000_1000;
        for (int k = 0; k < 5; k++) begin
            load(next_pc);
            next_pc = next_pc + 32'h8;
            cycle(1'b0, 1'b0, 2, 0);
        end

        // drain down to one entry, then over-ask for consume
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 0, 2);
        cycle(1'b0, 1'b0, 0, 1);
        cycle(1'b0, 1'b0, 0, 2);
        load(32'h0000_2000);
        cycle(1'b0, 1'b0, 3, 0);

        // clear the sticky flag, then stream across several pointer wraps
        cycle(1'b1, 1'b0, 2, 0);
        next_pc = 32'h1c00_0000;
        for (int k = 0; k < 21; k++) begin
            load(next_pc);
            next_pc = next_pc + 32'h8;
            cycle(1'b0, 1'b0, 2, 2);
        end

        // build to six entries with an overflow recorded, then flush
        load(next_pc); next_pc = next_pc + 32'h8;
        cycle(1'b0, 1'b0, 3, 0);
        load(next_pc); next_pc = next_pc + 32'h8;
        cycle(1'b0, 1'b0, 2, 0);
        load(next_pc);
        cycle(1'b0, 1'b1, 2, 1);

        // reset and flush together behave as reset
        load(32'h0000_3000);
        cycle(1'b0, 1'b0, 2, 0);
        cycle(1'b1, 1'b1, 2, 1);

        // exception on lane 1 only, then shift it onto decode lane 0
        load(32'h0000_4000);
        lane_exc[1] = 1'b1;
        lane_et[1]  = 6'h08;
        cycle(1'b0, 1'b0, 2, 0);
        load(32'h0000_5000);
        cycle(1'b0, 1'b0, 0, 1);
        cycle(1'b0, 1'b0, 0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
